// File: rtl/op_loader.sv
`default_nettype none
// ============================================================================
// Module   : op_loader
// Purpose  : Host-side driver for the switch/handshake operand-entry protocol
//            of the supervisory state machine. On a start pulse it pulses
//            the downstream reset, then presents four operand words one at a
//            time on the switch bus with timed handshake toggles. It then
//            walks the display phase and captures the real and imaginary
//            results from the LED bus.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk      in   1        system clock, rising edge
//   reset_n  in   1        asynchronous active-low reset
//   start    in   1        one-cycle transaction request (sampled in IDLE)
//   re_a_in  in   WIDTH    operand word 0
//   im_a_in  in   WIDTH    operand word 1
//   re_q_in  in   WIDTH    operand word 2
//   im_q_in  in   WIDTH    operand word 3
//   led_in   in   WIDTH    result bus from the supervisory state machine
//   sw_out   out  WIDTH+2  {downstream reset_n, handshake, data}
//   re_res   out  WIDTH    captured real result
//   im_res   out  WIDTH    captured imaginary result
//   busy     out  1        transaction in progress
//   done     out  1        one-cycle pulse at transaction end
// ============================================================================
module op_loader #(
    parameter int WIDTH     = 8,
    parameter int RST_CYC   = 4,
    parameter int SETUP_CYC = 2,
    parameter int HOLD_CYC  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] re_a_in,
    input  logic [WIDTH-1:0] im_a_in,
    input  logic [WIDTH-1:0] re_q_in,
    input  logic [WIDTH-1:0] im_q_in,
    input  logic [WIDTH-1:0] led_in,
    output logic [WIDTH+1:0] sw_out,
    output logic [WIDTH-1:0] re_res,
    output logic [WIDTH-1:0] im_res,
    output logic             busy,
    output logic             done
);

    // Counter holds at most (longest phase - 1).
    localparam int c_MAX_CYC = (RST_CYC > SETUP_CYC)
                             ? ((RST_CYC > HOLD_CYC) ? RST_CYC : HOLD_CYC)
                             : ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC);
    localparam int c_CNT_W   = (c_MAX_CYC > 1) ? $clog2(c_MAX_CYC) : 1;

    localparam logic [c_CNT_W-1:0] c_RST_LD   = c_CNT_W'(RST_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETUP_LD = c_CNT_W'(SETUP_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LD  = c_CNT_W'(HOLD_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_RST      = 3'd1;
    localparam logic [2:0] c_SETUP    = 3'd2;
    localparam logic [2:0] c_HIGH     = 3'd3;
    localparam logic [2:0] c_LOW      = 3'd4;
    localparam logic [2:0] c_WAIT_RE  = 3'd5;
    localparam logic [2:0] c_RES_HIGH = 3'd6;
    localparam logic [2:0] c_RES_LOW  = 3'd7;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_k;
    logic [WIDTH-1:0]   r_op0;
    logic [WIDTH-1:0]   r_op1;
    logic [WIDTH-1:0]   r_op2;
    logic [WIDTH-1:0]   r_op3;
    logic [WIDTH+1:0]   r_sw;
    logic [WIDTH-1:0]   r_re_res;
    logic [WIDTH-1:0]   r_im_res;
    logic               r_busy;
    logic               r_done;

    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [1:0]         w_k_next;
    logic               w_accept;
    logic               w_last;
    logic [WIDTH-1:0]   w_word;
    logic [WIDTH+1:0]   w_sw_next;

    // ------------------------------------------------------------------
    // Next-state logic. Every non-idle state lasts (load value + 1) cycles:
    // the counter is loaded on entry and the state advances once it is 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_k_next     = r_k;
        w_accept     = 1'b0;
        w_last       = (r_cnt == '0);

        if (r_state != c_IDLE && !w_last) begin
            w_cnt_next = r_cnt - c_CNT_ONE;
        end

        case (r_state)
            c_IDLE: begin
                // r_done high means this is the done cycle: no back-to-back start.
                if (start && !r_done) begin
                    w_accept     = 1'b1;
                    w_state_next = c_RST;
                    w_cnt_next   = c_RST_LD;
                    w_k_next     = 2'd0;
                end
            end
            c_RST: begin
                if (w_last) begin
                    w_state_next = c_SETUP;
                    w_cnt_next   = c_SETUP_LD;
                end
            end
            c_SETUP: begin
                if (w_last) begin
                    w_state_next = c_HIGH;
                    w_cnt_next   = c_HOLD_LD;
                end
            end
            c_HIGH: begin
                if (w_last) begin
                    w_state_next = c_LOW;
                    w_cnt_next   = c_HOLD_LD;
                end
            end
            c_LOW: begin
                if (w_last) begin
                    if (r_k == 2'd3) begin
                        w_state_next = c_WAIT_RE;
                        w_cnt_next   = c_HOLD_LD;
                    end else begin
                        w_state_next = c_SETUP;
                        w_cnt_next   = c_SETUP_LD;
                        w_k_next     = r_k + 2'd1;
                    end
                end
            end
            c_WAIT_RE: begin
                if (w_last) begin
                    w_state_next = c_RES_HIGH;
                    w_cnt_next   = c_HOLD_LD;
                end
            end
            c_RES_HIGH: begin
                if (w_last) begin
                    w_state_next = c_RES_LOW;
                    w_cnt_next   = c_HOLD_LD;
                end
            end
            c_RES_LOW: begin
                if (w_last) begin
                    w_state_next = c_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = c_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Switch bus is a registered decode of the *next* state, so the bus
    // changes on the same edge as the state it belongs to.
    // ------------------------------------------------------------------
    always_comb begin
        case (w_k_next)
            2'd0:    w_word = r_op0;
            2'd1:    w_word = r_op1;
            2'd2:    w_word = r_op2;
            default: w_word = r_op3;
        endcase

        w_sw_next = {1'b1, 1'b0, {WIDTH{1'b0}}};
        case (w_state_next)
            c_RST:          w_sw_next = '0;
            c_SETUP, c_LOW: w_sw_next = {1'b1, 1'b0, w_word};
            c_HIGH:         w_sw_next = {1'b1, 1'b1, w_word};
            c_RES_HIGH:     w_sw_next = {1'b1, 1'b1, {WIDTH{1'b0}}};
            default:        w_sw_next = {1'b1, 1'b0, {WIDTH{1'b0}}};
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_k      <= 2'd0;
            r_op0    <= '0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_op3    <= '0;
            r_sw     <= '0;
            r_re_res <= '0;
            r_im_res <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_k     <= w_k_next;
            r_sw    <= w_sw_next;
            r_busy  <= (w_state_next != c_IDLE);
            r_done  <= (r_state == c_RES_LOW) && w_last;

            if (w_accept) begin
                r_op0 <= re_a_in;
                r_op1 <= im_a_in;
                r_op2 <= re_q_in;
                r_op3 <= im_q_in;
            end

            // Results are sampled on the edge that ends each display phase.
            if (r_state == c_WAIT_RE && w_last) begin
                r_re_res <= led_in;
            end
            if (r_state == c_RES_HIGH && w_last) begin
                r_im_res <= led_in;
            end
        end
    end

    assign sw_out = r_sw;
    assign re_res = r_re_res;
    assign im_res = r_im_res;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule
`default_nettype wire
